pipe_cu: RTL and testbench
==========================

PIPE_CU -- requirements
Module: pipe_cu

Interface
REQ-001 Parameter RA_W, 5, register-address width; the link register is all-ones (31 at default).
REQ-002 Parameter ALUC_W, 4, aluc width; the upper bits above 4 are zero-extended.
REQ-003 Parameter FWD_EN, 1, selects the hazard mode: 1 forwards results, 0 stalls on every RAW hazard.
REQ-004 Parameter DELAY_SLOT, 1, selects the branch mode: 1 executes the delay slot, 0 squashes the instruction after a taken branch or jump.
REQ-005 clock  in  1  single clock; all registers update on the rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 op, func  in  6 each  fields of the ID-stage instruction.
REQ-008 rs, rt, rd  in  RA_W each  register fields of the ID-stage instruction.
REQ-009 rsrtequ  in  1  ID-stage compare result (forwarded rs operand equals forwarded rt operand).
REQ-010 wreg, m2reg, wmem, aluimm, shift, sext, jal  out  1 each  ID-stage decode; all forced to 0 on a stall or squash.
REQ-011 aluc  out  ALUC_W  ID-stage ALU code; forced to 0 on a stall or squash.
REQ-012 pcsource  out  2  next-PC select: 00 pc+4, 01 branch, 10 jr, 11 jump.
REQ-013 rn  out  RA_W  ID-stage destination register.
REQ-014 fwda, fwdb  out  2 each  operand selects: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data.
REQ-015 wpcir  out  1  PC/IF-ID write enable; 0 means stall.
REQ-016 ewreg, em2reg, ewmem, ealuimm, eshift, ejal  out  1 each  registered EX-stage controls; eern (RA_W) and ealuc (ALUC_W) are registered with them.
REQ-017 mwreg, mm2reg, mwmem, mrn  out  1/1/1/RA_W  registered MEM-stage controls.
REQ-018 wwreg, wm2reg, wrn  out  1/1/RA_W  registered WB-stage controls.

Function
REQ-019 Decode SHALL cover add, sub, and, or, xor, sll, srl, sra, jr, hamm (func 110010, aluc 1011), addi, andi, ori, xori, lw, sw, beq, bne, lui, j and jal, using the existing MIPS encodings and aluc values.
REQ-020 An unrecognised opcode SHALL decode as a bubble: all write enables 0 and pcsource 00.
REQ-021 rn SHALL be 31 (all-ones) for jal, rt for any regrt-class instruction, and rd otherwise.
REQ-022 Source usage: rs is read by all instructions except sll, srl, sra, lui, j and jal; rt is read by R-type instructions except jr, and by sw, beq and bne.
REQ-023 A match SHALL never be flagged against register 0.
REQ-024 Forwarding (FWD_EN=1), for fwda/fwdb independently:
  - EX writer with ~em2reg and eern==src -> 01;
  - else MEM writer with mrn==src -> 10 if ~mm2reg, 11 if mm2reg;
  - else 00.
  - EX has priority over MEM.
REQ-025 Load-use stall (FWD_EN=1): when ewreg&em2reg and eern equals a used source, wpcir SHALL be 0 for exactly one cycle and a bubble SHALL enter EX.
REQ-026 With FWD_EN=0, any used source matching eern (ewreg) or mrn (mwreg) SHALL stall, and fwda/fwdb SHALL stay 00.
REQ-027 The register file is write-through; a WB-stage write SHALL never stall.
REQ-028 pcsource SHALL be 01 on beq&rsrtequ or bne&~rsrtequ, 10 on jr, 11 on j/jal; while stalled it SHALL be forced to 00.
REQ-029 With DELAY_SLOT=0, a taken branch, jr or jump SHALL set a squash flag. The next ID instruction then decodes as a bubble and the flag clears after one cycle. A stall holds the flag.
REQ-030 Pipeline registers ID->EX->MEM->WB SHALL advance every cycle; the stall bubble clears only the ID->EX controls.
REQ-031 Latency: ID decode is registered to EX after 1 cycle, MEM after 2, and WB after 3.
REQ-032 A stall and a squash in the same cycle SHALL resolve as a stall; the squash is applied after the stall releases.

Reset
REQ-033 While resetn is 0, all EX/MEM/WB registers and the squash flag SHALL be 0, making every stage a bubble.
REQ-034 Outputs under reset: eern/mrn/wrn are 0, fwda/fwdb are 00 and wpcir is 1.
REQ-035 Reset asserted mid-stall or mid-squash SHALL clear that state on the same cycle, without waiting for a clock edge.

Structure
REQ-036 A shared package SHALL hold the opcode/func constants, aluc codes, pcsource and forward-select encodings, and the link-register index.
REQ-037 The combinational decoder SHALL be one sub-module, cu_decode. The hazard logic, forwarding logic and pipeline registers SHALL live in pipe_cu.

Verification
REQ-038 add r3,r1,r2 followed by sub r4,r3,r1 -> fwda=01 in the sub's ID cycle, with wpcir remaining 1.
REQ-039 lw r5,0(r0) followed by add r6,r5,r5 -> wpcir=0 for one cycle, the EX bubble has ewreg=0, and fwda=fwdb=11 on the next cycle.
REQ-040 beq with rsrtequ=1 at DELAY_SLOT=0 -> pcsource=01, and the following instruction reaches EX with ewreg=ewmem=0.
REQ-041 jal at DELAY_SLOT=1 -> rn=31 and pcsource=11; the delay-slot instruction executes normally, and wrn=31 with wwreg=1 three cycles later.
REQ-042 FWD_EN=0 with add r3 followed by or r7,r3,r3 -> wpcir=0 for two cycles, then fwda=00.
REQ-043 resetn pulled low during a load-use stall -> within the same cycle wpcir=1 and ewreg=mwreg=wwreg=0, with no clock edge required.

Source files
------------

// File: rtl/pipe_cu_pkg.sv
// Shared encodings for the five-stage pipeline control unit: MIPS opcode/func
// fields, ALU codes, next-PC and operand-forward selects, and the decode bundle.
package pipe_cu_pkg;

   localparam int ALU_W    = 4;
   localparam int LINK_REG = 31;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_HAMM = 6'b110010;

   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_LUI  = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_HAMM = 4'b1011;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1111;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b01,
      PC_JR  = 2'b10,
      PC_JMP = 2'b11
   } pcsrc_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_EXA  = 2'b01,
      FWD_MEMA = 2'b10,
      FWD_MEMD = 2'b11
   } fwd_e;

   typedef struct packed {
      logic             wreg;
      logic             m2reg;
      logic             wmem;
      logic             aluimm;
      logic             shift;
      logic             sext;
      logic             jal;
      logic             regrt;
      logic             use_rs;
      logic             use_rt;
      logic [ALU_W-1:0] aluc;
      pcsrc_e           pcsource;
   } dec_t;

   // EX wins over MEM; a load still in EX has no data yet and falls through.
   function automatic fwd_e fwd_sel(input logic ex_hit, input logic ex_load,
                                    input logic mem_hit, input logic mem_load);
      if (ex_hit && !ex_load) return FWD_EXA;
      if (mem_hit) return mem_load ? FWD_MEMD : FWD_MEMA;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_cu_if.sv
// ID-stage instruction fields in, decode/hazard/pipeline controls out.
interface pipe_cu_if #(
   parameter int RA_W   = 5,
   parameter int ALUC_W = 4
);
   logic [5:0]        op;
   logic [5:0]        func;
   logic [RA_W-1:0]   rs;
   logic [RA_W-1:0]   rt;
   logic [RA_W-1:0]   rd;
   logic              rsrtequ;

   logic              wreg, m2reg, wmem, aluimm, shift, sext, jal;
   logic [ALUC_W-1:0] aluc;
   logic [1:0]        pcsource;
   logic [RA_W-1:0]   rn;
   logic [1:0]        fwda, fwdb;
   logic              wpcir;

   logic              ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
   logic [RA_W-1:0]   eern;
   logic [ALUC_W-1:0] ealuc;
   logic              mwreg, mm2reg, mwmem;
   logic [RA_W-1:0]   mrn;
   logic              wwreg, wm2reg;
   logic [RA_W-1:0]   wrn;

   modport slave (
      input  op, func, rs, rt, rd, rsrtequ,
      output wreg, m2reg, wmem, aluimm, shift, sext, jal, aluc, pcsource, rn,
             fwda, fwdb, wpcir,
             ewreg, em2reg, ewmem, ealuimm, eshift, ejal, eern, ealuc,
             mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn
   );

   modport master (
      output op, func, rs, rt, rd, rsrtequ,
      input  wreg, m2reg, wmem, aluimm, shift, sext, jal, aluc, pcsource, rn,
             fwda, fwdb, wpcir,
             ewreg, em2reg, ewmem, ealuimm, eshift, ejal, eern, ealuc,
             mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn
   );
endinterface

// File: rtl/pipe_cu_decode.sv
// Purely combinational ID-stage instruction decoder; unknown encodings
// come out as an all-zero bubble.
module cu_decode
   import pipe_cu_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   input  logic       i_rsrtequ,
   output dec_t       o_dec
);

   dec_t w_d;

   always_comb begin
      w_d          = '0;
      w_d.pcsource = PC_SEQ;
      case (i_op)
         OP_RTYPE: begin
            case (i_func)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_HAMM: begin
                  w_d.wreg   = 1'b1;
                  w_d.use_rs = 1'b1;
                  w_d.use_rt = 1'b1;
                  case (i_func)
                     FN_SUB:  w_d.aluc = ALU_SUB;
                     FN_AND:  w_d.aluc = ALU_AND;
                     FN_OR:   w_d.aluc = ALU_OR;
                     FN_XOR:  w_d.aluc = ALU_XOR;
                     FN_HAMM: w_d.aluc = ALU_HAMM;
                     default: w_d.aluc = ALU_ADD;
                  endcase
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  w_d.wreg   = 1'b1;
                  w_d.shift  = 1'b1;
                  w_d.use_rt = 1'b1;
                  w_d.aluc   = (i_func == FN_SLL) ? ALU_SLL :
                               (i_func == FN_SRL) ? ALU_SRL : ALU_SRA;
               end
               FN_JR: begin
                  w_d.use_rs   = 1'b1;
                  w_d.pcsource = PC_JR;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
            w_d.wreg   = 1'b1;
            w_d.regrt  = 1'b1;
            w_d.aluimm = 1'b1;
            w_d.use_rs = 1'b1;
            w_d.sext   = (i_op == OP_ADDI);
            w_d.aluc   = (i_op == OP_ANDI) ? ALU_AND :
                         (i_op == OP_ORI)  ? ALU_OR  :
                         (i_op == OP_XORI) ? ALU_XOR : ALU_ADD;
         end
         OP_LW: begin
            w_d.wreg   = 1'b1;
            w_d.m2reg  = 1'b1;
            w_d.regrt  = 1'b1;
            w_d.aluimm = 1'b1;
            w_d.sext   = 1'b1;
            w_d.use_rs = 1'b1;
         end
         OP_SW: begin
            w_d.wmem   = 1'b1;
            w_d.aluimm = 1'b1;
            w_d.sext   = 1'b1;
            w_d.use_rs = 1'b1;
            w_d.use_rt = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_d.sext   = 1'b1;
            w_d.use_rs = 1'b1;
            w_d.use_rt = 1'b1;
            w_d.aluc   = ALU_XOR;
            if ((i_op == OP_BEQ) == i_rsrtequ) w_d.pcsource = PC_BR;
         end
         OP_LUI: begin
            w_d.wreg   = 1'b1;
            w_d.regrt  = 1'b1;
            w_d.aluimm = 1'b1;
            w_d.aluc   = ALU_LUI;
         end
         OP_J: w_d.pcsource = PC_JMP;
         OP_JAL: begin
            w_d.wreg     = 1'b1;
            w_d.jal      = 1'b1;
            w_d.pcsource = PC_JMP;
         end
         default: ;
      endcase
   end

   assign o_dec = w_d;

endmodule

// File: rtl/pipe_cu.sv
// Pipelined MIPS control unit: decode, RAW hazard stall/forward selection,
// branch squash and the ID->EX->MEM->WB control registers.
module pipe_cu
   import pipe_cu_pkg::*;
#(
   parameter int RA_W       = 5,
   parameter int ALUC_W     = 4,
   parameter int FWD_EN     = 1,
   parameter int DELAY_SLOT = 1
) (
   input  logic       clock,
   input  logic       resetn,
   pipe_cu_if.slave   bus
);

   localparam logic SQUASH_EN = (DELAY_SLOT == 0);

   dec_t              w_dec;
   logic [RA_W-1:0]   w_rn;
   logic              w_use_rs, w_use_rt;
   logic              w_a_ex, w_b_ex, w_a_mem, w_b_mem;
   logic              w_ld_use, w_any_raw, w_stall, w_kill, w_taken;
   fwd_e              w_fwda, w_fwdb;
   pcsrc_e            w_pcsource;
   logic [ALUC_W-1:0] w_aluc;
   logic              w_wreg, w_m2reg, w_wmem, w_aluimm, w_shift, w_sext, w_jal;

   logic              r_squash;
   logic              r_ewreg, r_em2reg, r_ewmem, r_ealuimm, r_eshift, r_ejal;
   logic [RA_W-1:0]   r_eern;
   logic [ALUC_W-1:0] r_ealuc;
   logic              r_mwreg, r_mm2reg, r_mwmem;
   logic [RA_W-1:0]   r_mrn;
   logic              r_wwreg, r_wm2reg;
   logic [RA_W-1:0]   r_wrn;

   cu_decode u_decode (
      .i_op      (bus.op),
      .i_func    (bus.func),
      .i_rsrtequ (bus.rsrtequ),
      .o_dec     (w_dec)
   );

   assign w_rn = w_dec.jal ? {RA_W{1'b1}} : (w_dec.regrt ? bus.rt : bus.rd);

   // A squashed instruction never reads its sources, so it can never stall.
   assign w_use_rs = w_dec.use_rs & ~r_squash;
   assign w_use_rt = w_dec.use_rt & ~r_squash;

   assign w_a_ex  = r_ewreg & (r_eern != '0) & (r_eern == bus.rs);
   assign w_b_ex  = r_ewreg & (r_eern != '0) & (r_eern == bus.rt);
   assign w_a_mem = r_mwreg & (r_mrn  != '0) & (r_mrn  == bus.rs);
   assign w_b_mem = r_mwreg & (r_mrn  != '0) & (r_mrn  == bus.rt);

   assign w_ld_use  = r_em2reg & ((w_use_rs & w_a_ex) | (w_use_rt & w_b_ex));
   assign w_any_raw = (w_use_rs & (w_a_ex | w_a_mem)) | (w_use_rt & (w_b_ex | w_b_mem));
   assign w_stall   = (FWD_EN != 0) ? w_ld_use : w_any_raw;
   assign w_kill    = w_stall | r_squash;

   assign w_fwda = (FWD_EN != 0) ? fwd_sel(w_a_ex, r_em2reg, w_a_mem, r_mm2reg) : FWD_RF;
   assign w_fwdb = (FWD_EN != 0) ? fwd_sel(w_b_ex, r_em2reg, w_b_mem, r_mm2reg) : FWD_RF;

   assign w_wreg     = w_dec.wreg   & ~w_kill;
   assign w_m2reg    = w_dec.m2reg  & ~w_kill;
   assign w_wmem     = w_dec.wmem   & ~w_kill;
   assign w_aluimm   = w_dec.aluimm & ~w_kill;
   assign w_shift    = w_dec.shift  & ~w_kill;
   assign w_sext     = w_dec.sext   & ~w_kill;
   assign w_jal      = w_dec.jal    & ~w_kill;
   assign w_aluc     = w_kill ? '0 : ALUC_W'(w_dec.aluc);
   assign w_pcsource = w_kill ? PC_SEQ : w_dec.pcsource;
   assign w_taken    = (w_pcsource != PC_SEQ);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_squash  <= 1'b0;
         r_ewreg   <= 1'b0;
         r_em2reg  <= 1'b0;
         r_ewmem   <= 1'b0;
         r_ealuimm <= 1'b0;
         r_eshift  <= 1'b0;
         r_ejal    <= 1'b0;
         r_eern    <= '0;
         r_ealuc   <= '0;
         r_mwreg   <= 1'b0;
         r_mm2reg  <= 1'b0;
         r_mwmem   <= 1'b0;
         r_mrn     <= '0;
         r_wwreg   <= 1'b0;
         r_wm2reg  <= 1'b0;
         r_wrn     <= '0;
      end else begin
         // The redirect is taken only once the branch leaves ID, so a stalled
         // branch defers its squash until the stall releases.
         r_squash  <= w_stall ? r_squash : (SQUASH_EN & w_taken);
         r_ewreg   <= w_wreg;
         r_em2reg  <= w_m2reg;
         r_ewmem   <= w_wmem;
         r_ealuimm <= w_aluimm;
         r_eshift  <= w_shift;
         r_ejal    <= w_jal;
         r_eern    <= w_rn;
         r_ealuc   <= w_aluc;
         r_mwreg   <= r_ewreg;
         r_mm2reg  <= r_em2reg;
         r_mwmem   <= r_ewmem;
         r_mrn     <= r_eern;
         r_wwreg   <= r_mwreg;
         r_wm2reg  <= r_mm2reg;
         r_wrn     <= r_mrn;
      end
   end

   assign bus.wreg     = w_wreg;
   assign bus.m2reg    = w_m2reg;
   assign bus.wmem     = w_wmem;
   assign bus.aluimm   = w_aluimm;
   assign bus.shift    = w_shift;
   assign bus.sext     = w_sext;
   assign bus.jal      = w_jal;
   assign bus.aluc     = w_aluc;
   assign bus.pcsource = w_pcsource;
   assign bus.rn       = w_rn;
   assign bus.fwda     = w_fwda;
   assign bus.fwdb     = w_fwdb;
   assign bus.wpcir    = ~w_stall;
   assign bus.ewreg    = r_ewreg;
   assign bus.em2reg   = r_em2reg;
   assign bus.ewmem    = r_ewmem;
   assign bus.ealuimm  = r_ealuimm;
   assign bus.eshift   = r_eshift;
   assign bus.ejal     = r_ejal;
   assign bus.eern     = r_eern;
   assign bus.ealuc    = r_ealuc;
   assign bus.mwreg    = r_mwreg;
   assign bus.mm2reg   = r_mm2reg;
   assign bus.mwmem    = r_mwmem;
   assign bus.mrn      = r_mrn;
   assign bus.wwreg    = r_wwreg;
   assign bus.wm2reg   = r_wm2reg;
   assign bus.wrn      = r_wrn;

endmodule

// File: tb/tb_pipe_cu.sv
// Directed bench for pipe_cu: three instances cover forwarding+delay slot,
// forwarding+squash, and stall-only hazard handling.
module tb_pipe_cu;
   import pipe_cu_pkg::*;

   localparam logic [5:0] OP_BUB = 6'b111111;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   pipe_cu_if #(.RA_W(5), .ALUC_W(4)) ifa ();
   pipe_cu_if #(.RA_W(5), .ALUC_W(4)) ifb ();
   pipe_cu_if #(.RA_W(5), .ALUC_W(4)) ifc ();

   pipe_cu #(.RA_W(5), .ALUC_W(4), .FWD_EN(1), .DELAY_SLOT(1)) u_a (
      .clock(clk), .resetn(rst_n), .bus(ifa));
   pipe_cu #(.RA_W(5), .ALUC_W(4), .FWD_EN(1), .DELAY_SLOT(0)) u_b (
      .clock(clk), .resetn(rst_n), .bus(ifb));
   pipe_cu #(.RA_W(5), .ALUC_W(4), .FWD_EN(0), .DELAY_SLOT(1)) u_c (
      .clock(clk), .resetn(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_i(input logic [5:0] op, input logic [5:0] func,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic eq);
      ifa.op = op; ifa.func = func; ifa.rs = rs; ifa.rt = rt; ifa.rd = rd; ifa.rsrtequ = eq;
      ifb.op = op; ifb.func = func; ifb.rs = rs; ifb.rt = rt; ifb.rd = rd; ifb.rsrtequ = eq;
      ifc.op = op; ifc.func = func; ifc.rs = rs; ifc.rt = rt; ifc.rd = rd; ifc.rsrtequ = eq;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      set_i(OP_BUB, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      smp();
      chk("rst_wpcir", ifa.wpcir, 1);
      chk("rst_ewreg", ifa.ewreg, 0);
      chk("rst_eern",  ifa.eern, 0);
      chk("rst_mrn",   ifa.mrn, 0);
      chk("rst_wrn",   ifa.wrn, 0);
      chk("rst_fwda",  ifa.fwda, 0);

      // forwarding chain on A
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("add_wreg", ifa.wreg, 1);
      chk("add_rn",   ifa.rn, 3);
      chk("add_aluc", ifa.aluc, 0);
      cyc(); set_i(OP_RTYPE, FN_SUB, 5'd3, 5'd1, 5'd4, 1'b0); smp();
      chk("sub_fwda",  ifa.fwda, 1);
      chk("sub_fwdb",  ifa.fwdb, 0);
      chk("sub_wpcir", ifa.wpcir, 1);
      chk("sub_aluc",  ifa.aluc, 4);
      chk("add_eern",  ifa.eern, 3);
      cyc(); set_i(OP_RTYPE, FN_OR, 5'd3, 5'd4, 5'd8, 1'b0); smp();
      chk("or_fwda_mem", ifa.fwda, 2);
      chk("or_fwdb_ex",  ifa.fwdb, 1);
      chk("add_mrn",     ifa.mrn, 3);
      cyc(); set_i(OP_BUB, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("bub_wreg",  ifa.wreg, 0);
      chk("add_wwreg", ifa.wwreg, 1);
      chk("add_wrn",   ifa.wrn, 3);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd0, 5'd0, 5'd9, 1'b0); smp();
      chk("r0_fwda", ifa.fwda, 0);
      chk("r0_fwdb", ifa.fwdb, 0);

      // load-use on A
      cyc(); set_i(OP_LW, 6'd0, 5'd0, 5'd5, 5'd0, 1'b0); smp();
      chk("lw_m2reg", ifa.m2reg, 1);
      chk("lw_sext",  ifa.sext, 1);
      chk("lw_rn",    ifa.rn, 5);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd5, 5'd5, 5'd6, 1'b0); smp();
      chk("lu_wpcir0", ifa.wpcir, 0);
      chk("lu_wreg0",  ifa.wreg, 0);
      cyc(); smp();
      chk("lu_wpcir1", ifa.wpcir, 1);
      chk("lu_bubble", ifa.ewreg, 0);
      chk("lu_fwda",   ifa.fwda, 3);
      chk("lu_fwdb",   ifa.fwdb, 3);
      cyc(); set_i(OP_BUB, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); smp();
      chk("lu_ewreg", ifa.ewreg, 1);
      chk("lu_eern",  ifa.eern, 6);

      // assorted decodes on A
      cyc(); set_i(OP_SW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0); smp();
      chk("sw_wmem", ifa.wmem, 1);
      chk("sw_wreg", ifa.wreg, 0);
      cyc(); set_i(OP_RTYPE, FN_HAMM, 5'd1, 5'd2, 5'd10, 1'b0); smp();
      chk("hamm_aluc", ifa.aluc, 11);
      cyc(); set_i(OP_RTYPE, FN_SRA, 5'd0, 5'd2, 5'd11, 1'b0); smp();
      chk("sra_shift", ifa.shift, 1);
      chk("sra_aluc",  ifa.aluc, 15);
      cyc(); set_i(OP_LUI, 6'd0, 5'd0, 5'd12, 5'd0, 1'b0); smp();
      chk("lui_aluc", ifa.aluc, 6);
      chk("lui_rn",   ifa.rn, 12);
      cyc(); set_i(OP_RTYPE, FN_JR, 5'd31, 5'd0, 5'd0, 1'b0); smp();
      chk("jr_pcs", ifa.pcsource, 2);
      cyc(); set_i(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0); smp();
      chk("beq_nt_pcs", ifa.pcsource, 0);
      cyc(); set_i(OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0); smp();
      chk("bne_t_pcs", ifa.pcsource, 1);

      // jal with delay slot on A
      cyc(); set_i(OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0); smp();
      chk("jal_rn",  ifa.rn, 31);
      chk("jal_pcs", ifa.pcsource, 3);
      chk("jal_jal", ifa.jal, 1);
      cyc(); set_i(OP_ADDI, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0); smp();
      chk("slot_wreg", ifa.wreg, 1);
      chk("slot_rn",   ifa.rn, 7);
      chk("jal_ejal",  ifa.ejal, 1);
      cyc(); set_i(OP_BUB, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc(); smp();
      chk("jal_wwreg", ifa.wwreg, 1);
      chk("jal_wrn",   ifa.wrn, 31);

      // squash on B
      #1 rst_n = 1'b0;
      cyc(); rst_n = 1'b1;
      set_i(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b1); smp();
      chk("b_beq_pcs", ifb.pcsource, 1);
      cyc(); set_i(OP_RTYPE, FN_SUB, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("b_sq_wreg", ifb.wreg, 0);
      chk("b_sq_aluc", ifb.aluc, 0);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("b_sq_ewreg", ifb.ewreg, 0);
      chk("b_sq_ewmem", ifb.ewmem, 0);
      chk("b_clr_wreg", ifb.wreg, 1);
      cyc(); set_i(OP_LW, 6'd0, 5'd0, 5'd5, 5'd0, 1'b0);
      cyc(); set_i(OP_BEQ, 6'd0, 5'd5, 5'd5, 5'd0, 1'b1); smp();
      chk("b_stbr_wpcir", ifb.wpcir, 0);
      chk("b_stbr_pcs",   ifb.pcsource, 0);
      cyc(); smp();
      chk("b_rel_wpcir", ifb.wpcir, 1);
      chk("b_rel_pcs",   ifb.pcsource, 1);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd6, 1'b0); smp();
      chk("b_late_sq", ifb.wreg, 0);
      cyc(); smp();
      chk("b_after_sq", ifb.wreg, 1);
      cyc(); set_i(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b1);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("b_pre_rst", ifb.wreg, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("b_rst_sq_clr", ifb.wreg, 1);

      // stall-only mode on C
      cyc(); rst_n = 1'b1;
      set_i(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0); smp();
      chk("c_add_wpcir", ifc.wpcir, 1);
      cyc(); set_i(OP_RTYPE, FN_OR, 5'd3, 5'd3, 5'd7, 1'b0); smp();
      chk("c_st1_wpcir", ifc.wpcir, 0);
      chk("c_st1_fwda",  ifc.fwda, 0);
      cyc(); smp();
      chk("c_st2_wpcir", ifc.wpcir, 0);
      cyc(); smp();
      chk("c_go_wpcir", ifc.wpcir, 1);
      chk("c_go_fwda",  ifc.fwda, 0);
      chk("c_go_aluc",  ifc.aluc, 5);

      // reset during a load-use stall on A
      cyc(); set_i(OP_LW, 6'd0, 5'd0, 5'd5, 5'd0, 1'b0);
      cyc(); set_i(OP_RTYPE, FN_ADD, 5'd5, 5'd5, 5'd6, 1'b0); smp();
      chk("a_pre_rst_wpcir", ifa.wpcir, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("a_rst_wpcir", ifa.wpcir, 1);
      chk("a_rst_ewreg", ifa.ewreg, 0);
      chk("a_rst_mwreg", ifa.mwreg, 0);
      chk("a_rst_wwreg", ifa.wwreg, 0);
      cyc(); rst_n = 1'b1;
      smp();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
